// File: rtl/uart_stream_bridge.sv
// UART <-> byte-stream bridge: ser_tx frames feed an RX FIFO, a TX FIFO feeds ser_rx frames.
// Define UART_BRIDGE_ERRCNT_EN to add the saturating err_count output.

module uart_bridge_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        do_push, do_pop;

    // Extra pointer bit distinguishes full from empty without losing a slot.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end
endmodule

module uart_stream_bridge #(
    parameter int CLK_DIV  = 417,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic       clk_48mhz,
    input  logic       resetn,
    input  logic       ser_tx,
    output logic       ser_rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
`ifdef UART_BRIDGE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam logic [15:0] DIV    = 16'(CLK_DIV);
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF   = 16'(CLK_DIV / 2);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic        sync1_q, sync2_q, rx_prev_q;
    logic [2:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_push, rx_tick;
    logic        rx_empty, rx_full;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        ser_rx_q, ser_rx_d;
    logic        tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_head;
    logic        rdy_en_q;

    assign out_valid = ~rx_empty;
    assign in_ready  = rdy_en_q & ~tx_full;
    assign ser_rx    = ser_rx_q;

    uart_bridge_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_48mhz),
        .rst_ni  (resetn),
        .push_i  (rx_push & ~rx_full),
        .data_i  (rx_shift_q),
        .pop_i   (out_valid & out_ready),
        .data_o  (out_data),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    uart_bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_48mhz),
        .rst_ni  (resetn),
        .push_i  (in_valid & in_ready),
        .data_i  (in_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );

    // Sampling on cnt==1 puts the start-bit sample mid-bit despite the IDLE detect cycle.
    assign rx_tick = (rx_cnt_q == 16'd1);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF;
                end
            end
            RX_START: begin
                if (!rx_tick) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (!sync2_q) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = DIV;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!rx_tick) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else begin
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = DIV;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (!rx_tick) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (sync2_q) begin
                    rx_push    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (sync2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TX_START;
                    tx_cnt_d   = DIV_M1;
                end
            end
            TX_START: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else begin
                    tx_shift_d = {1'b1, tx_shift_q[7:1]};
                    tx_cnt_d   = DIV_M1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TX_START;
                    tx_cnt_d   = DIV_M1;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line level is registered from the current state, so it trails the FSM by one edge.
    always_comb begin
        ser_rx_d = 1'b1;
        case (tx_state_q)
            TX_START: ser_rx_d = 1'b0;
            TX_DATA:  ser_rx_d = tx_shift_q[0];
            default:  ser_rx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            ser_rx_q   <= 1'b1;
            rdy_en_q   <= 1'b0;
        end else begin
            sync1_q    <= ser_tx;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            ser_rx_q   <= ser_rx_d;
            rdy_en_q   <= 1'b1;
        end
    end

`ifdef UART_BRIDGE_ERRCNT_EN
    logic [7:0] err_q;
    logic       frame_err, overrun;

    assign frame_err = (rx_state_q == RX_STOP) && rx_tick && !sync2_q;
    assign overrun   = rx_push & rx_full;
    assign err_count = err_q;

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            err_q <= '0;
        end else if ((frame_err || overrun) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_uart_stream_bridge.sv
// Self-checking bench for uart_stream_bridge (CLK_DIV=4, depth-4 FIFOs).
// Serial waveforms and FIFO contents are predicted from frame timing rules.

module tb_uart_stream_bridge;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ser_tx = 1'b1;
    logic       ser_rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
`ifdef UART_BRIDGE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int tests = 0;
    int fails = 0;
    int err_model = 0;
    logic [7:0] tx_q[$];

    uart_stream_bridge #(
        .CLK_DIV  (DIV),
        .RX_DEPTH (DEPTH),
        .TX_DEPTH (DEPTH)
    ) dut (
        .clk_48mhz (clk),
        .resetn    (resetn),
        .ser_tx    (ser_tx),
        .ser_rx    (ser_rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
`ifdef UART_BRIDGE_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        ser_tx = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            ser_tx = b[i];
            repeat (DIV) tick();
        end
        ser_tx = stop;
        repeat (DIV) tick();
        ser_tx = 1'b1;
    endtask

    task automatic check_err(input string name);
`ifdef UART_BRIDGE_ERRCNT_EN
        tests++;
        if (err_count !== 8'(err_model)) begin
            fails++;
            $display("FAIL %s err_count got %0d want %0d", name, err_count, err_model);
        end
`endif
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        tests++;
        if (ser_rx !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state ser_rx=%b out_valid=%b in_ready=%b want 1 0 0",
                     ser_rx, out_valid, in_ready);
        end
        err_model = 0;
        check_err("reset");
        resetn = 1'b1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release in_ready got %b want 0", in_ready);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_edge in_ready got %b want 1", in_ready);
        end
    endtask

    // Pushes tx_q on consecutive edges (k=0 is edge N) and checks the whole line trace.
    task automatic run_tx(input string name);
        int n;
        int pushes, pops, t, f, b;
        logic exp_ser, exp_rdy;
        n = tx_q.size();
        for (int k = 0; k < n * FRAME + 12; k++) begin
            if (k < n) begin
                in_valid = 1'b1;
                in_data  = tx_q[k];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            tick();
            exp_ser = 1'b1;
            if (k >= 2) begin
                t = k - 2;
                f = t / FRAME;
                b = (t % FRAME) / DIV;
                if (f < n) begin
                    if (b == 0)      exp_ser = 1'b0;
                    else if (b == 9) exp_ser = 1'b1;
                    else             exp_ser = tx_q[f][b-1];
                end
            end
            tests++;
            if (ser_rx !== exp_ser) begin
                fails++;
                $display("FAIL %s ser_rx cycle %0d got %b want %b", name, k, ser_rx, exp_ser);
            end
            pushes = (k + 1 < n) ? k + 1 : n;
            pops   = (k >= 1) ? ((k - 1) / FRAME + 1) : 0;
            if (pops > n) pops = n;
            exp_rdy = ((pushes - pops) < DEPTH);
            tests++;
            if (in_ready !== exp_rdy) begin
                fails++;
                $display("FAIL %s in_ready cycle %0d got %b want %b", name, k, in_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_tx_single();
        tx_q = {};
        tx_q.push_back(8'hA5);
        run_tx("tx_a5");
    endtask

    task automatic test_back_to_back();
        tx_q = {};
        for (int i = 0; i < DEPTH + 1; i++) tx_q.push_back(8'($urandom));
        run_tx("tx_b2b");
    endtask

    task automatic test_rx_stall();
        out_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
                fails++;
                $display("FAIL rx_stall cycle %0d valid=%b data=%h want 1 3c", i, out_valid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rx_stall_pop out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_overrun(input string name, input logic rand_data);
        logic [7:0] model[$];
        logic [7:0] b;
        model = {};
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = rand_data ? 8'($urandom) : 8'(i + 1);
            if (model.size() < DEPTH) model.push_back(b);
            else if (err_model < 255) err_model++;
            send_frame(b, 1'b1);
        end
        repeat (4) tick();
        check_err(name);
        while (model.size() > 0) begin
            b = model.pop_front();
            tests++;
            if (out_valid !== 1'b1 || out_data !== b) begin
                fails++;
                $display("FAIL %s drain valid=%b data=%h want 1 %h", name, out_valid, out_data, b);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s empty out_valid got %b want 0", name, out_valid);
        end
    endtask

    task automatic expect_and_pop(input string name, input logic [7:0] b);
        tests++;
        if (out_valid !== 1'b1 || out_data !== b) begin
            fails++;
            $display("FAIL %s valid=%b data=%h want 1 %h", name, out_valid, out_data, b);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_framing();
        send_frame(8'hF0, 1'b0);
        ser_tx = 1'b0;
        repeat (8) tick();
        ser_tx = 1'b1;
        repeat (8) tick();
        if (err_model < 255) err_model++;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL framing_nopush out_valid got %b want 0", out_valid);
        end
        check_err("framing");
        send_frame(8'h55, 1'b1);
        repeat (4) tick();
        expect_and_pop("framing_next", 8'h55);
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        ser_tx = 1'b0;
        tick();
        ser_tx = 1'b1;
        repeat (12) tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL glitch out_valid got %b want 0", out_valid);
        end
        check_err("glitch");
        b = 8'($urandom);
        send_frame(b, 1'b1);
        repeat (4) tick();
        expect_and_pop("glitch_next", b);
    endtask

    task automatic test_rx_random();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            repeat (4) tick();
            expect_and_pop("rx_random", b);
            repeat ($urandom_range(0, 5)) tick();
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] b;
        out_ready = 1'b0;
        send_frame(8'($urandom), 1'b1);
        repeat (4) tick();
        b = 8'($urandom) & 8'hF7;
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        // Edge N was the tick above; data bit 3 spans edges N+18..N+21.
        repeat (18) tick();
        tests++;
        if (ser_rx !== 1'b0) begin
            fails++;
            $display("FAIL mid_tx bit3 ser_rx got %b want 0", ser_rx);
        end
        #2;
        resetn = 1'b0;
        #1;
        err_model = 0;
        tests++;
        if (ser_rx !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_tx_reset ser_rx=%b out_valid=%b in_ready=%b want 1 0 0",
                     ser_rx, out_valid, in_ready);
        end
        check_err("mid_tx_reset");
        tick();
        #2;
        resetn = 1'b1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_tx_release in_ready got %b want 0", in_ready);
        end
        tick();
        for (int i = 0; i < FRAME; i++) begin
            tests++;
            if (in_ready !== 1'b1 || ser_rx !== 1'b1 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_tx_after cycle %0d in_ready=%b ser_rx=%b out_valid=%b want 1 1 0",
                         i, in_ready, ser_rx, out_valid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_stall();
        test_overrun("overrun_seq", 1'b0);
        test_overrun("overrun_rand", 1'b1);
        test_framing();
        test_glitch();
        test_rx_random();
        test_reset_mid_tx();
        test_tx_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_stream_bridge.md
UART_STREAM_BRIDGE -- requirements
Module: uart_stream_bridge

Interface
REQ-001 Parameter CLK_DIV, default 417, clk_48mhz cycles per UART bit (115200 baud at 48 MHz); legal range 4..65535.
REQ-002 Parameter RX_DEPTH, default 16, entries in the ser_tx->out FIFO; power of two, 2..256.
REQ-003 Parameter TX_DEPTH, default 16, entries in the in->ser_rx FIFO; power of two, 2..256.
REQ-004 clk_48mhz  input  1  sole clock.
REQ-005 resetn  input  1  asynchronous assert, active-low reset.
REQ-006 ser_tx  input  1  serial line driven by the SoC UART; idles high.
REQ-007 ser_rx  output  1  serial line driven toward the SoC UART; idles high.
REQ-008 out_data / out_valid / out_ready  output 8 / output 1 / input 1  bytes received on ser_tx, toward usb_uart.
REQ-009 in_data / in_valid / in_ready  input 8 / input 1 / output 1  bytes from usb_uart, to be sent on ser_rx.
REQ-010 err_count  output  8  saturating error counter; present only with UART_BRIDGE_ERRCNT_EN.

Function
REQ-011 Transfer on either stream SHALL occur exactly on a rising edge where valid and ready are both high.
REQ-012 out_valid SHALL equal RX FIFO not-empty; out_data SHALL be the FIFO head, held stable while out_valid && !out_ready.
REQ-013 in_ready SHALL equal TX FIFO not-full; it is independent of in_valid.
REQ-014 Both FIFOs: simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo depth; full and empty SHALL be exact (no lost slot).
REQ-015 ser_tx SHALL pass through a 2-flop synchronizer (flops reset to 1) before use.
REQ-016 RX FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-017 IDLE->START on a synchronized high-to-low edge; bit counter loads CLK_DIV/2 (integer division).
REQ-018 START: at half-bit, line low -> DATA; line high -> IDLE (glitch rejected, nothing pushed).
REQ-019 DATA: sample 8 bits at CLK_DIV intervals, LSB first.
REQ-020 STOP: sample at CLK_DIV after the last data bit; high -> push byte, go IDLE; low -> framing error, discard byte, go WAIT_HIGH.
REQ-021 WAIT_HIGH -> IDLE when the synchronized line is high.
REQ-022 A valid byte arriving at a full RX FIFO SHALL be dropped (overrun); FIFO contents are unchanged.
REQ-023 A pushed RX byte SHALL raise out_valid on the edge after the stop-bit sample when the FIFO was empty.
REQ-024 TX FSM states are IDLE, START, DATA, STOP; IDLE pops the FIFO when non-empty and loads the shift register.
REQ-025 Frame: start bit low, 8 data bits LSB first, one stop bit high, each exactly CLK_DIV cycles; no parity.
REQ-026 Byte accepted on edge N into an empty TX FIFO with TX idle: ser_rx SHALL go low on edge N+2.
REQ-027 With the TX FIFO non-empty at stop-bit end, the next start bit SHALL follow immediately: back-to-back period is 10*CLK_DIV cycles.
REQ-028 ser_rx SHALL be driven from a register (glitch-free).

Reset
REQ-029 On resetn low: both FIFOs empty, FSMs IDLE, ser_rx=1, out_valid=0, in_ready=0, err_count=0.
REQ-030 in_ready SHALL rise on the first edge after resetn deasserts.
REQ-031 Reset mid-frame SHALL abort the frame; ser_rx returns high asynchronously; partial RX bytes are discarded.

Configuration
REQ-032 Macro UART_BRIDGE_ERRCNT_EN defined: err_count port exists and increments by one per framing error or RX overrun, saturating at 255; reset-only clear.
REQ-033 Macro UART_BRIDGE_ERRCNT_EN undefined: no err_count port and no counter logic; all other behaviour is identical.

Verification (CLK_DIV=4, depths 4)
REQ-034 in_data=0xA5 accepted at edge N, TX idle -> ser_rx low at N+2; bits 1,0,1,0,0,1,0,1 then high; 40 cycles per frame.
REQ-035 Frame 0x3C on ser_tx, out_ready=0 -> out_valid=1 with out_data=0x3C, held over 20 stalled cycles.
REQ-036 5 frames 0x01..0x05 with out_ready=0 -> 0x01..0x04 delivered in order, 0x05 dropped; err_count=1 when UART_BRIDGE_ERRCNT_EN.
REQ-037 Frame with low stop bit -> no push, FSM waits for high line; err_count increments; next good frame 0x55 received correctly.
REQ-038 1-cycle low glitch on ser_tx -> no push, RX returns IDLE.
REQ-039 resetn pulsed low during TX bit 3 -> ser_rx=1 immediately, FIFOs empty, in_ready=1 one edge after release.
